// File: rtl/disaggregator.sv
// ---------------------------------------------------------------------------
// disaggregator
//   Takes one wide word of FETCH_WIDTH packed lanes from a first-word-fall-
//   through sender and hands the lanes to a narrow receiver one per cycle,
//   lane 0 first. The number of active lanes per word can be changed at run
//   time. A new width takes effect only between words: the word being
//   emitted always finishes with the width it was loaded under.
//
// Ports
//   clk                 rising-edge clock
//   rst_n               synchronous active-low reset
//   sender_data         wide input word, lane i at [(i+1)*DATA_WIDTH-1 : i*DATA_WIDTH]
//   sender_empty_n      sender holds a word
//   sender_deq          pop the sender this cycle (combinational)
//   receiver_data       current lane, zero when nothing is buffered
//   receiver_full_n     receiver can accept a lane
//   receiver_enq        push receiver_data this cycle (combinational)
//   change_fetch_width  one-cycle request to load a new lane count
//   input_fetch_width   requested lane count (0 or > FETCH_WIDTH means FETCH_WIDTH)
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module disaggregator #(
  parameter int DATA_WIDTH  = 8,
  parameter int FETCH_WIDTH = 2,
  parameter int CNT_WIDTH   = 3
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [FETCH_WIDTH*DATA_WIDTH-1:0] sender_data,
  input  logic                              sender_empty_n,
  output logic                              sender_deq,
  output logic [DATA_WIDTH-1:0]             receiver_data,
  input  logic                              receiver_full_n,
  output logic                              receiver_enq,
  input  logic                              change_fetch_width,
  input  logic [CNT_WIDTH-1:0]              input_fetch_width
);

  localparam int                   WIDE_W = FETCH_WIDTH * DATA_WIDTH;
  localparam logic [CNT_WIDTH-1:0] FW_C   = CNT_WIDTH'(FETCH_WIDTH);

  logic [WIDE_W-1:0]    data_buf, data_buf_nxt;
  logic                 valid, valid_nxt;
  logic [CNT_WIDTH-1:0] idx, idx_nxt;
  logic [CNT_WIDTH-1:0] aw, aw_nxt;
  logic                 pend, pend_nxt;
  logic [CNT_WIDTH-1:0] pend_w, pend_w_nxt;
  logic                 last;
  logic                 enq;
  logic                 deq;

  // Zero or out-of-range requests fall back to the full word width.
  function automatic logic [CNT_WIDTH-1:0] clamp_width(input logic [CNT_WIDTH-1:0] w);
    logic [CNT_WIDTH-1:0] r;
    if ((w == '0) || (w > FW_C)) r = FW_C;
    else                         r = w;
    return r;
  endfunction

  assign last = valid & (idx == (aw - CNT_WIDTH'(1)));

  // Handshakes are masked while rst_n is low so the word being discarded
  // cannot leak a lane, and nothing is popped that would then be dropped.
  assign enq = rst_n & valid & receiver_full_n;

  // A pending width change holds off loading until the buffer is empty for
  // one cycle, which is the cycle the new width is applied.
  assign deq = rst_n & sender_empty_n
             & (~valid | (last & receiver_full_n))
             & ~(pend & ~valid)
             & ~(pend & last & receiver_full_n);

  assign sender_deq   = deq;
  assign receiver_enq = enq;

  always_comb begin
    receiver_data = '0;
    if (valid) begin
      for (int i = 0; i < FETCH_WIDTH; i++) begin
        if (idx == CNT_WIDTH'(i)) receiver_data = data_buf[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    data_buf_nxt = data_buf;
    valid_nxt    = valid;
    idx_nxt      = idx;
    aw_nxt       = aw;
    pend_nxt     = pend;
    pend_w_nxt   = pend_w;

    if (!valid && pend) begin
      aw_nxt   = clamp_width(pend_w);
      pend_nxt = 1'b0;
    end
    // A request arriving in the apply cycle stays pending for the next gap.
    if (change_fetch_width) begin
      pend_nxt   = 1'b1;
      pend_w_nxt = input_fetch_width;
    end

    if (deq) begin
      data_buf_nxt = sender_data;
      valid_nxt    = 1'b1;
      idx_nxt      = '0;
    end else if (enq) begin
      if (last) begin
        valid_nxt = 1'b0;
        idx_nxt   = '0;
      end else begin
        idx_nxt = idx + CNT_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_buf <= '0;
      valid    <= 1'b0;
      idx      <= '0;
      aw       <= FW_C;
      pend     <= 1'b0;
      pend_w   <= '0;
    end else begin
      data_buf <= data_buf_nxt;
      valid    <= valid_nxt;
      idx      <= idx_nxt;
      aw       <= aw_nxt;
      pend     <= pend_nxt;
      pend_w   <= pend_w_nxt;
    end
  end

endmodule
